// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load extension and write-back mux.
//
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   StallW, FlushW     hold W register / load a bubble into it
//   ValidM .. PCPlus4M M-stage instruction fields
//   WE3, A3, WD3       register-file write port
//   RdW, RegWriteW     destination and write intent for the hazard unit
//   LoadMisalignW      misaligned LH/LHU/LW in W
//   RetireCount        retired-instruction count
//
// Optional feature: define WB_RETIRE_CNT_EN to build the 32-bit retire counter;
// otherwise RetireCount is tied to 0 and no counter flops exist.
// Load extension supports D_WIDTH = 32 only.
module mem_wb_stage #(
  parameter int unsigned A_WIDTH = 5,
  parameter int unsigned D_WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               StallW,
  input  logic               FlushW,
  input  logic               ValidM,
  input  logic               RegWriteM,
  input  logic [1:0]         ResultSrcM,
  input  logic [2:0]         Funct3M,
  input  logic [A_WIDTH-1:0] RdM,
  input  logic [D_WIDTH-1:0] ALUResultM,
  input  logic [D_WIDTH-1:0] ReadDataM,
  input  logic [D_WIDTH-1:0] PCPlus4M,
  output logic               WE3,
  output logic [A_WIDTH-1:0] A3,
  output logic [D_WIDTH-1:0] WD3,
  output logic [A_WIDTH-1:0] RdW,
  output logic               RegWriteW,
  output logic               LoadMisalignW,
  output logic [31:0]        RetireCount
);

  logic               valid_q;
  logic               reg_write_q;
  logic [1:0]         result_src_q;
  logic [2:0]         funct3_q;
  logic [A_WIDTH-1:0] rd_q;
  logic [D_WIDTH-1:0] alu_q;
  logic [D_WIDTH-1:0] rdata_q;
  logic [D_WIDTH-1:0] pc4_q;

  // W register: reset > flush > stall > capture. Flush only kills valid/write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      funct3_q     <= 3'b000;
      rd_q         <= '0;
      alu_q        <= '0;
      rdata_q      <= '0;
      pc4_q        <= '0;
    end else if (FlushW) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (!StallW) begin
      valid_q      <= ValidM;
      reg_write_q  <= RegWriteM;
      result_src_q <= ResultSrcM;
      funct3_q     <= Funct3M;
      rd_q         <= RdM;
      alu_q        <= ALUResultM;
      rdata_q      <= ReadDataM;
      pc4_q        <= PCPlus4M;
    end
  end

  // Byte and halfword selection by the address offset.
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [D_WIDTH-1:0] ld_val;

  always_comb begin
    ld_byte = rdata_q[7:0];
    case (alu_q[1:0])
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      2'd3:    ld_byte = rdata_q[31:24];
      default: ld_byte = rdata_q[7:0];
    endcase
    ld_half = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
  end

  always_comb begin
    ld_val = rdata_q;
    case (funct3_q)
      3'b000:  ld_val = {{(D_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {{(D_WIDTH-8){1'b0}}, ld_byte};
      3'b001:  ld_val = {{(D_WIDTH-16){ld_half[15]}}, ld_half};
      3'b101:  ld_val = {{(D_WIDTH-16){1'b0}}, ld_half};
      default: ld_val = rdata_q;
    endcase
  end

  // Write-back select; 2'b11 aliases the ALU path.
  always_comb begin
    WD3 = alu_q;
    case (result_src_q)
      2'b01:   WD3 = ld_val;
      2'b10:   WD3 = pc4_q;
      default: WD3 = alu_q;
    endcase
  end

  logic is_half;
  logic is_word;
  assign is_half = (funct3_q == 3'b001) || (funct3_q == 3'b101);
  assign is_word = (funct3_q == 3'b010);

  assign LoadMisalignW = valid_q && (result_src_q == 2'b01) &&
                         ((is_half && alu_q[0]) || (is_word && (alu_q[1:0] != 2'b00)));

  assign RdW       = rd_q;
  assign A3        = rd_q;
  assign RegWriteW = valid_q & reg_write_q;
  // Writes to x0 and faulting loads are suppressed; a stalled write repeats.
  assign WE3       = valid_q & RegWriteW & (rd_q != '0) & ~LoadMisalignW;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;

  // Counts the W instruction as it leaves the stage; wraps naturally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      retire_cnt <= 32'd0;
    end else if (valid_q && !StallW && !FlushW) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  assign RetireCount = retire_cnt;
`else
  assign RetireCount = 32'd0;
`endif

endmodule
